// File: rtl/icache_responder_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
// The cache takes the slave view; the fetch stage and memory model take the master view.
interface icache_responder_if;
  logic [31:0] ins_address;
  logic        ins_req;
  logic        flush;
  logic [31:0] instruction;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  modport slave (
    input  ins_address, ins_req, flush, mem_rdata, mem_valid,
    output instruction, hit, mem_req, mem_addr
  );

  modport master (
    output ins_address, ins_req, flush, mem_rdata, mem_valid,
    input  instruction, hit, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with a zero-latency hit path.
// A miss fills the whole line, beat 0 first, from a word-wide memory port.
module icache_responder #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input logic               clk,
  input logic               rst,
  icache_responder_if.slave bus
);

  localparam int OFF  = $clog2(WORDS) + 2;
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - OFF - IDX;
  localparam int BW   = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [31:0]       fill_base_q, fill_base_d;
  logic              flush_pend_q, flush_pend_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [31:0]       data_q [LINES][WORDS];
  logic [TAGW-1:0]   tag_q  [LINES];

  logic [IDX-1:0]    idx;
  logic [BW-1:0]     word;
  logic [TAGW-1:0]   tag_in;
  logic [IDX-1:0]    fill_idx;
  logic [TAGW-1:0]   fill_tag;
  logic              lookup_hit;
  logic              data_we;
  logic              tag_we;
  logic              unused_addr_bits;

  assign idx      = bus.ins_address[OFF+IDX-1:OFF];
  assign word     = bus.ins_address[OFF-1:2];
  assign tag_in   = bus.ins_address[31:OFF+IDX];
  assign fill_idx = fill_base_q[OFF+IDX-1:OFF];
  assign fill_tag = fill_base_q[31:OFF+IDX];
  assign unused_addr_bits = ^bus.ins_address[1:0];

  // A flush in IDLE suppresses the hit in the same cycle it clears the valid bits.
  assign lookup_hit = bus.ins_req && (state_q == IDLE) && !bus.flush &&
                      valid_q[idx] && (tag_q[idx] == tag_in);

  assign bus.hit         = lookup_hit;
  assign bus.instruction = lookup_hit ? data_q[idx][word] : '0;
  assign bus.mem_req     = (state_q == FILL);
  assign bus.mem_addr    = (state_q == FILL) ? fill_base_q + (32'(beat_q) << 2) : '0;

  assign data_we = (state_q == FILL) && bus.mem_valid;
  assign tag_we  = (state_q == DONE);

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no path can infer a latch.
    state_d      = state_q;
    beat_d       = beat_q;
    fill_base_d  = fill_base_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;

    case (state_q)
      IDLE: begin
        if (bus.flush) valid_d = '0;
        if (bus.ins_req && !lookup_hit) begin
          fill_base_d  = {bus.ins_address[31:OFF], {OFF{1'b0}}};
          beat_d       = '0;
          flush_pend_d = 1'b0;
          valid_d[idx] = 1'b0;
          state_d      = FILL;
        end
      end
      FILL: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(WORDS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        // A flush seen at any point of the fill discards the freshly filled line too.
        if (flush_pend_q || bus.flush) valid_d = '0;
        else                           valid_d[fill_idx] = 1'b1;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      fill_base_q  <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      fill_base_q  <= fill_base_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // NOTE: data and tag arrays are deliberately not reset; the valid vector alone guards them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (data_we) data_q[fill_idx][beat_q] <= bus.mem_rdata;
      if (tag_we)  tag_q[fill_idx]          <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus random fetches
// checked against a line-residency model and a synthetic memory image.
module tb_icache_responder;

  localparam int LINES      = 16;
  localparam int WORDS      = 4;
  localparam int OFF        = $clog2(WORDS) + 2;
  localparam int IDX        = $clog2(LINES);
  localparam int LINE_BYTES = WORDS * 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  icache_responder_if bus ();

  icache_responder #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: which line-aligned address is resident at each index.
  logic [31:0] line_of [int];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1111_0000 + (a >> 2);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(LINE_BYTES - 1);
  endfunction

  function automatic int line_idx(input logic [31:0] a);
    return int'((a >> OFF) % LINES);
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    bus.ins_req   = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic flush_idle();
    @(negedge clk);
    bus.ins_req   = 1'b0;
    bus.flush     = 1'b1;
    bus.mem_valid = 1'b0;
    line_of.delete();
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  // One fetch: a hit completes in one cycle; a miss is served with gaps drawn from
  // [gap_lo, gap_hi] and may see a flush pulse on the first cycle of beat flush_beat.
  task automatic fetch(input logic [31:0] addr, input int gap_lo, input int gap_hi,
                       input int flush_beat, input bit flush_now);
    logic [31:0] base;
    int          idx;
    int          gap;
    bit          flushed;
    base    = line_base(addr);
    idx     = line_idx(addr);
    flushed = 1'b0;

    @(negedge clk);
    bus.ins_req     = 1'b1;
    bus.ins_address = addr;
    bus.flush       = flush_now;
    bus.mem_valid   = 1'b0;
    if (flush_now) line_of.delete();
    #1;
    if (line_of.exists(idx) && line_of[idx] == base) begin
      check("hit", 32'(bus.hit), 32'd1);
      check("hit_data", bus.instruction, mem_word(addr));
      check("hit_no_mem_req", 32'(bus.mem_req), 32'd0);
      return;
    end
    check("miss", 32'(bus.hit), 32'd0);
    check("miss_instr_zero", bus.instruction, 32'd0);
    line_of.delete(idx);

    for (int b = 0; b < WORDS; b++) begin
      gap = int'($urandom_range(gap_hi, gap_lo));
      for (int g = 0; g <= gap; g++) begin
        @(negedge clk);
        bus.ins_address = $urandom;
        bus.flush       = (b == flush_beat) && (g == 0);
        if (bus.flush) flushed = 1'b1;
        bus.mem_valid   = (g == gap);
        bus.mem_rdata   = (g == gap) ? mem_word(base + 32'(4 * b)) : $urandom;
        #1;
        check("fill_mem_req", 32'(bus.mem_req), 32'd1);
        check("fill_mem_addr", bus.mem_addr, base + 32'(4 * b));
        check("fill_no_hit", 32'(bus.hit), 32'd0);
      end
    end

    @(negedge clk);
    bus.mem_valid   = 1'b0;
    bus.flush       = 1'b0;
    bus.ins_address = addr;
    bus.ins_req     = !flushed;
    #1;
    check("done_mem_req", 32'(bus.mem_req), 32'd0);
    check("done_no_hit", 32'(bus.hit), 32'd0);
    if (flushed) begin
      line_of.delete();
      return;
    end
    line_of[idx] = base;

    @(negedge clk);
    #1;
    check("hit_after_fill", 32'(bus.hit), 32'd1);
    check("fill_data", bus.instruction, mem_word(addr));
  endtask

  // Abandon a fill with reset after two beats; caller guarantees addr misses.
  task automatic rst_midfill(input logic [31:0] addr);
    logic [31:0] base;
    base = line_base(addr);
    @(negedge clk);
    bus.ins_req     = 1'b1;
    bus.ins_address = addr;
    bus.flush       = 1'b0;
    bus.mem_valid   = 1'b0;
    #1;
    check("rst_fill_miss", 32'(bus.hit), 32'd0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_rdata = mem_word(base + 32'(4 * b));
      #1;
      check("rst_fill_mem_addr", bus.mem_addr, base + 32'(4 * b));
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.ins_req   = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    line_of.delete();
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;

    rst             = 1'b1;
    bus.ins_req     = 1'b0;
    bus.ins_address = '0;
    bus.flush       = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_valid   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_hit", 32'(bus.hit), 32'd0);
    check("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_instr", bus.instruction, 32'd0);

    // First fill with back-to-back beats, then the rest of the line hits.
    fetch(32'h0000_0000, 0, 0, -1, 1'b0);
    fetch(32'h0000_0004, 0, 0, -1, 1'b0);
    fetch(32'h0000_0008, 0, 0, -1, 1'b0);
    fetch(32'h0000_000C, 0, 0, -1, 1'b0);

    // Slow memory: three idle cycles before every beat.
    fetch(32'h0000_0040, 3, 3, -1, 1'b0);

    // Conflict on index 0.
    fetch(32'h0000_0100, 0, 1, -1, 1'b0);
    fetch(32'h0000_0000, 0, 1, -1, 1'b0);

    // Flush in IDLE, then the same address misses.
    fetch(32'h0000_0004, 0, 0, -1, 1'b0);
    flush_idle();
    fetch(32'h0000_0004, 0, 0, -1, 1'b0);

    // Flush during a fill: line is not kept.
    fetch(32'h0000_0200, 0, 1, 1, 1'b0);
    fetch(32'h0000_0200, 0, 1, -1, 1'b0);
    // Flush coinciding with a resident lookup.
    fetch(32'h0000_0208, 0, 0, -1, 1'b1);

    // Reset mid-fill, then a clean refill from beat 0.
    rst_midfill(32'h0000_0300);
    fetch(32'h0000_0300, 0, 0, -1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(3, 0)) << (OFF + IDX)) |
          (32'($urandom_range(LINES - 1, 0)) << OFF) |
          (32'($urandom_range(WORDS - 1, 0)) << 2) |
          32'($urandom_range(3, 0));
      r = int'($urandom_range(99, 0));
      if (r >= 8 && r < 12) idle_cycle();
      fetch(a, 0, 2, (r < 8) ? int'($urandom_range(WORDS - 1, 0)) : -1, r >= 95);
    end

    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
